mult_err_accum: RTL

//  Downstream consumer of the 8x8 approximate Booth multipliers (hybrid radix-4/radix-8 BM-family).

---
 rtl/mult_err_pkg.sv | 18 +
 rtl/mult_err_accum_err_stage.sv | 54 +++++
 rtl/mult_err_accum.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/mult_err_pkg.sv
// Shared types, widths and helpers for the approximate-multiplier error accumulator.
package mult_err_pkg;

    localparam int WIDTH  = 8;
    localparam int PROD_W = 2 * WIDTH;
    localparam int ERR_W  = PROD_W + 1;
    localparam int CNT_W  = 17;
    localparam int ACC_W  = 2 * WIDTH + CNT_W + 1;
    localparam int SQ_W   = 2 * PROD_W + CNT_W;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} err_state_t;

    // |err| always fits in PROD_W bits: err lies in [-49152, 49023] for 8x8 operands.
    function automatic logic [PROD_W-1:0] abs_err(input logic signed [ERR_W-1:0] e);
        return PROD_W'(e[ERR_W-1] ? -e : e);
    endfunction

endpackage

// File: rtl/mult_err_accum_err_stage.sv
// S1/S2 datapath: registers the approximate product together with the exact product,
// then forms err = prod - x*y and ED = |err| combinationally for the accumulators.
module err_stage
    import mult_err_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    input  logic [WIDTH-1:0]         x,
    input  logic [WIDTH-1:0]         y,
    input  logic [PROD_W-1:0]        prod,
    output logic                     out_valid,
    output logic signed [ERR_W-1:0]  err,
    output logic [PROD_W-1:0]        ed
);

    logic                      s1_valid_q, s1_valid_d;
    logic [PROD_W-1:0]         prod_q, prod_d;
    logic signed [PROD_W-1:0]  exact_q, exact_d;

    // S1 input side: the exact product is formed here so only products cross the register;
    // the raw operands are not needed past this point.
    always_comb begin
        s1_valid_d = in_valid;
        prod_d     = prod_q;
        exact_d    = exact_q;
        if (in_valid) begin
            prod_d  = prod;
            exact_d = $signed({{WIDTH{x[WIDTH-1]}}, x}) * $signed({{WIDTH{y[WIDTH-1]}}, y});
        end
    end

    // S1 register; reset only needs to kill the valid bit, data is don't-care when invalid.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            prod_q     <= '0;
            exact_q    <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            prod_q     <= prod_d;
            exact_q    <= exact_d;
        end
    end

    // S2: one extra bit on err so prod - exact never truncates.
    always_comb begin
        err = $signed({prod_q[PROD_W-1], prod_q}) - $signed({exact_q[PROD_W-1], exact_q});
        ed  = abs_err(err);
    end

    assign out_valid = s1_valid_q;

endmodule

// File: rtl/mult_err_accum.sv
// Error-metric accumulator for approximate 8x8 multipliers: run FSM, sample counter and
// sum_ed / sum_err / max_ed / err_cnt accumulators fed by err_stage.
// Optional feature: define MULT_ERR_SQ_EN to add the sum_sq (sum of ED^2) output.
module mult_err_accum
    import mult_err_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [CNT_W-1:0]    n_samples,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [WIDTH-1:0]    x,
    input  logic [WIDTH-1:0]    y,
    input  logic [PROD_W-1:0]   prod,
    output logic                busy,
    output logic                done,
    output logic [ACC_W-1:0]    sum_ed,
    output logic [ACC_W-1:0]    sum_err,
    output logic [PROD_W-1:0]   max_ed,
    output logic [CNT_W-1:0]    err_cnt,
`ifdef MULT_ERR_SQ_EN
    output logic [SQ_W-1:0]     sum_sq,
`endif
    output logic [CNT_W-1:0]    smp_cnt
);

    err_state_t                state_q, state_d;
    logic [CNT_W-1:0]          n_q, n_d;
    logic [CNT_W-1:0]          smp_cnt_q, smp_cnt_d;
    logic                      drain_q, drain_d;
    logic [ACC_W-1:0]          sum_ed_q, sum_ed_d;
    logic [ACC_W-1:0]          sum_err_q, sum_err_d;
    logic [PROD_W-1:0]         max_ed_q, max_ed_d;
    logic [CNT_W-1:0]          err_cnt_q, err_cnt_d;
`ifdef MULT_ERR_SQ_EN
    logic [SQ_W-1:0]           sum_sq_q, sum_sq_d;
    logic [2*PROD_W-1:0]       ed_sq;
`endif

    logic                      accept;
    logic                      s2_valid;
    logic signed [ERR_W-1:0]   s2_err;
    logic [PROD_W-1:0]         s2_ed;

    assign in_ready = (state_q == RUN) && (smp_cnt_q < n_q);
    assign accept   = in_valid && in_ready;
    assign busy     = (state_q == RUN) || (state_q == DRAIN);
    assign done     = (state_q == DONE);

    err_stage u_err_stage (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (accept),
        .x         (x),
        .y         (y),
        .prod      (prod),
        .out_valid (s2_valid),
        .err       (s2_err),
        .ed        (s2_ed)
    );

`ifdef MULT_ERR_SQ_EN
    assign ed_sq = (2*PROD_W)'(s2_ed) * (2*PROD_W)'(s2_ed);
`endif

    // Next-state, counters and accumulators; start (legal only when the pipe is empty) wins over accumulation.
    always_comb begin
        state_d   = state_q;
        n_d       = n_q;
        smp_cnt_d = smp_cnt_q;
        drain_d   = drain_q;
        sum_ed_d  = sum_ed_q;
        sum_err_d = sum_err_q;
        max_ed_d  = max_ed_q;
        err_cnt_d = err_cnt_q;
`ifdef MULT_ERR_SQ_EN
        sum_sq_d  = sum_sq_q;
`endif

        if (s2_valid) begin
            sum_ed_d  = sum_ed_q + ACC_W'(s2_ed);
            sum_err_d = sum_err_q + {{(ACC_W-ERR_W){s2_err[ERR_W-1]}}, s2_err};
            if (s2_ed > max_ed_q) max_ed_d = s2_ed;
            if (s2_err != '0)     err_cnt_d = err_cnt_q + CNT_W'(1);
`ifdef MULT_ERR_SQ_EN
            sum_sq_d  = sum_sq_q + SQ_W'(ed_sq);
`endif
        end

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d   = RUN;
                    n_d       = n_samples;
                    smp_cnt_d = '0;
                    sum_ed_d  = '0;
                    sum_err_d = '0;
                    max_ed_d  = '0;
                    err_cnt_d = '0;
`ifdef MULT_ERR_SQ_EN
                    sum_sq_d  = '0;
`endif
                end
            end
            RUN: begin
                drain_d = 1'b0;
                if (accept) smp_cnt_d = smp_cnt_q + CNT_W'(1);
                if (smp_cnt_q == n_q) state_d = DRAIN;
            end
            DRAIN: begin
                // Two drain cycles, the second also confirming the pipe holds nothing.
                drain_d = 1'b1;
                if (drain_q && !s2_valid) state_d = DONE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and metric registers; reset aborts any run and clears everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            n_q       <= '0;
            smp_cnt_q <= '0;
            drain_q   <= 1'b0;
            sum_ed_q  <= '0;
            sum_err_q <= '0;
            max_ed_q  <= '0;
            err_cnt_q <= '0;
`ifdef MULT_ERR_SQ_EN
            sum_sq_q  <= '0;
`endif
        end else begin
            state_q   <= state_d;
            n_q       <= n_d;
            smp_cnt_q <= smp_cnt_d;
            drain_q   <= drain_d;
            sum_ed_q  <= sum_ed_d;
            sum_err_q <= sum_err_d;
            max_ed_q  <= max_ed_d;
            err_cnt_q <= err_cnt_d;
`ifdef MULT_ERR_SQ_EN
            sum_sq_q  <= sum_sq_d;
`endif
        end
    end

    assign sum_ed  = sum_ed_q;
    assign sum_err = sum_err_q;
    assign max_ed  = max_ed_q;
    assign err_cnt = err_cnt_q;
    assign smp_cnt = smp_cnt_q;
`ifdef MULT_ERR_SQ_EN
    assign sum_sq  = sum_sq_q;
`endif

endmodule
